// File: rtl/gf2_toom3_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential GF(2)[x] 3-way split multiplier.
interface gf2_toom3_mul_seq_if #(
    parameter int N = 233
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] c;

    modport master (output start, a, b, input busy, done, c);
    modport slave  (input start, a, b, output busy, done, c);
endinterface

// File: rtl/gf2_toom3_mul_seq.sv
// Sequential carry-less multiplier: operands split into three limbs, nine digit-serial
// shift-and-XOR sub-products, one combine cycle, then PIP output register stages.
module gf2_toom3_mul_seq #(
    parameter int N     = 233,
    parameter int DIGIT = 1,
    parameter int PIP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    gf2_toom3_mul_seq_if.slave bus
);
    localparam int S    = (N + 2) / 3;
    localparam int ITER = (S + DIGIT - 1) / DIGIT;
    localparam int AW   = 2 * S - 1;
    localparam int CW   = 2 * N;
    localparam int KMAX = (ITER > PIP) ? ITER : PIP;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int PW   = $clog2(S + DIGIT + 1);
    localparam logic [KW-1:0] ITER_LAST = KW'(ITER - 1);
    localparam logic [KW-1:0] PIP_LAST  = KW'((PIP > 0) ? PIP - 1 : 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL   = 2'd1;
    localparam logic [1:0] COMB  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [PW-1:0]    pos;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [3*S-1:0]   a_pad;
    logic [3*S-1:0]   b_pad;
    logic [S-1:0]     a_limb [3];
    logic [S-1:0]     b_limb [3];
    logic [AW-1:0]    acc      [9];
    logic [AW-1:0]    acc_next [9];
    logic [DIGIT-1:0] win;
    logic [AW-1:0]    d_t, e_t, f_t, g_t, h_t;
    logic [CW-1:0]    r_comb;
    logic [CW-1:0]    tail_r;
    logic             vld_comb;
    logic             tail_vld;
    logic             done_q;
    logic [CW-1:0]    c_q;

    // Operand capture: only an accepted start loads the limbs.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
    end

    assign a_pad = (3*S)'(a_q);
    assign b_pad = (3*S)'(b_q);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_limb[i] = a_pad[i*S +: S];
            b_limb[i] = b_pad[i*S +: S];
        end
    end

    // Accumulator index is 3*(a-limb) + (b-limb); window bits at or beyond S shift in as zero.
    always_comb begin
        win = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc_next[3*i+j] = acc[3*i+j];
                win = DIGIT'(a_limb[i] >> pos);
                for (int d = 0; d < DIGIT; d++) begin
                    if (win[d])
                        acc_next[3*i+j] = acc_next[3*i+j] ^ (AW'(b_limb[j]) << (pos + PW'(d)));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            pos   <= '0;
            for (int i = 0; i < 9; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= MUL;
                        k     <= '0;
                        pos   <= '0;
                        for (int i = 0; i < 9; i++) acc[i] <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    pos <= pos + PW'(DIGIT);
                    if (k == ITER_LAST) begin
                        state <= COMB;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                COMB: state <= (PIP > 0) ? DRAIN : IDLE;
                DRAIN: begin
                    if (k == PIP_LAST) begin
                        state <= IDLE;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combine stage: cross-limb terms folded at multiples of S.
    always_comb begin
        d_t = acc[8];
        e_t = acc[5] ^ acc[7];
        f_t = acc[2] ^ acc[4] ^ acc[6];
        g_t = acc[1] ^ acc[3];
        h_t = acc[0];
        r_comb = CW'(h_t) ^ (CW'(g_t) << S) ^ (CW'(f_t) << (2*S))
               ^ (CW'(e_t) << (3*S)) ^ (CW'(d_t) << (4*S));
    end

    assign vld_comb = (state == COMB);

    generate
        if (PIP == 0) begin : g_nopipe
            assign tail_r   = r_comb;
            assign tail_vld = vld_comb;
        end else begin : g_pipe
            logic [CW-1:0]  r_p [PIP];
            logic [PIP-1:0] vld_p;

            // Output stages p0..p(PIP-1) after the combine.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p <= '0;
                    for (int i = 0; i < PIP; i++) r_p[i] <= '0;
                end else begin
                    r_p[0]   <= r_comb;
                    vld_p[0] <= vld_comb;
                    for (int i = 1; i < PIP; i++) begin
                        r_p[i]   <= r_p[i-1];
                        vld_p[i] <= vld_p[i-1];
                    end
                end
            end

            assign tail_r   = r_p[PIP-1];
            assign tail_vld = vld_p[PIP-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            c_q    <= '0;
        end else begin
            done_q <= tail_vld;
            if (tail_vld) c_q <= tail_r;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.c    = c_q;
endmodule

// File: doc/gf2_toom3_mul_seq.md
# gf2_toom3_mul_seq

Parametrised sequential 3-way split multiplier for binary-field (GF(2)[x], carry-less) polynomials, the next generation of our fixed 233-bit Toom-Cook style multiplier. It adds a start/busy/done handshake and a configurable digit size (bits consumed per cycle), and supports any operand width. Internal pipeline depth is also configurable. It sits under the ECC field-arithmetic unit as the multiply engine.

## Interface
- N, 233: operand width in bits, N ≥ 3.
- DIGIT, 1: multiplier bits processed per cycle per sub-product, 1 ≤ DIGIT ≤ S.
- PIP, 4: output pipeline stages after the combine step, PIP ≥ 0.
- Derived, not overridable:
  - S = ceil(N/3): limb width.
  - ITER = ceil(S/DIGIT).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  N  multiplicand, polynomial, bit i = coeff of x^i.
- b  in  N  multiplier, same encoding.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; c valid in that cycle.
- c  out  2N  carry-less product a·b. Bit 2N-1 is always 0.

## Operation
- Acceptance: start=1 in IDLE latches a and b into internal registers. Later changes on a/b have no effect.
- Limb split:
  - a0 = a[S-1:0], a1 = a[2S-1:S], a2 = a[N-1:2S], zero-extended to S bits. Same split for b.
- Nine parallel shift-and-XOR sub-products, each accumulating 2S-1 bits. In each MUL cycle k, each accumulator XORs in (b-limb << j) for every set bit j of the a-limb in window [k·DIGIT, k·DIGIT+DIGIT-1]. Bits ≥ S are treated as 0.
- Term groups:
  - d = a2b2
  - e = a1b2 ^ a2b1
  - f = a0b2 ^ a1b1 ^ a2b0
  - g = a0b1 ^ a1b0
  - h = a0b0
  - Every sub-product uses its own counter/window. No cross-indexing between sub-products.
- Combine: r = h ^ (g<<S) ^ (f<<2S) ^ (e<<3S) ^ (d<<4S), truncated to 2N bits. The truncation only drops bits that are provably zero.
- FSM:
  - IDLE: start → MUL. Accumulators cleared and k=0 on entry.
  - MUL: ITER cycles, k increments each cycle; k=ITER-1 → COMB.
  - COMB: 1 cycle, registers r.
  - DRAIN: PIP cycles through shift stages. When PIP=0, DRAIN is skipped.
  - Last DRAIN cycle (or COMB if PIP=0) → IDLE. The FSM sits in IDLE in the done cycle.
- c updates only when done rises and holds that value until the next done or reset.
- start while busy=1 is ignored; there is no queuing.
- start in the done cycle is accepted, giving back-to-back operation.
- rst at any time, including mid-MUL:
  - FSM → IDLE; accumulators, pipeline, busy, done and c all clear to 0 on the next edge.
  - The in-flight operation is abandoned, and done never fires for it.

## Timing
- Reset values: busy=0, done=0, c=0, FSM=IDLE.
- Start sampled at edge T0 gives:
  - busy=1 from T0+1 to T0+ITER+1+PIP-1.
  - done=1 for exactly cycle T0+ITER+1+PIP, with busy=0 in that cycle.
- Latency for the defaults (N=233, DIGIT=1, PIP=4): S=78, ITER=78, done 83 cycles after the start edge.
- For N=233, DIGIT=8, PIP=0: ITER=10, latency 11.
- Throughput: one result per ITER+1+PIP cycles under back-to-back start.
- Critical path scales with DIGIT: DIGIT shifted XORs per accumulator per cycle.

## Test plan
- Defaults, a=1, b=1, start pulse → done exactly 83 cycles later, c=1, busy low in the done cycle.
- a=2^232 (x^232), b=2^232 → c has only bit 464 set. a=all-ones(233), b=1 → c=a.
- Sweep (N,DIGIT,PIP) ∈ {(233,1,4), (233,8,0), (163,4,2), (7,1,1)} with 500 random pairs each → c matches the bench carry-less reference model, and latency equals ITER+1+PIP.
- start re-asserted and a/b randomised every cycle while busy → those starts are ignored and the result equals the product of the operands latched at acceptance.
- start in the done cycle with new operands → second done after ITER+1+PIP more cycles with the correct product; c holds the first result in between.
- rst pulsed at MUL cycle 40, then immediate new start → no done for the aborted operation, c=0 after reset, new result correct at full latency.
